// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// against a shared req/ready memory, with a wait-state watchdog and illegal-op trap.
module mc_controller #(
    parameter int TIMEOUT      = 16,
    parameter int ILLEGAL_HALT = 0
) (
    input  logic       i_clk_w,
    input  logic       i_rst_w,
    input  logic [5:0] i_op_w,
    input  logic [5:0] i_funct_w,
    input  logic       i_zero_w,
    input  logic       i_mem_ready_w,
    output logic       o_mem_req_w,
    output logic       o_iord_w,
    output logic       o_mem_write_w,
    output logic       o_ir_write_w,
    output logic       o_pc_write_w,
    output logic       o_reg_dst_w,
    output logic       o_mem_to_reg_w,
    output logic       o_reg_write_w,
    output logic       o_alu_src_a_w,
    output logic [1:0] o_alu_src_b_w,
    output logic [2:0] o_alu_control_w,
    output logic [1:0] o_pc_src_w,
    output logic       o_illegal_w,
    output logic       o_timeout_w,
    output logic       o_halted_w,
    output logic [3:0] o_state_w
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic          abort_reg, abort_next;
    logic          waiting, expired;

    logic       mem_req, iord, mem_write, ir_write, pc_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       illegal, timeout, halted;

    always_ff @(posedge i_clk_w or posedge i_rst_w) begin
        if (i_rst_w) begin
            state_reg <= S_FETCH;
            count_reg <= '0;
            abort_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            abort_reg <= abort_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        abort_next  = 1'b0;
        waiting     = 1'b0;
        mem_req     = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b010;
        pc_src      = 2'b00;
        illegal     = 1'b0;
        timeout     = 1'b0;
        halted      = 1'b0;
        case (state_reg)
            S_FETCH: begin
                alu_src_b = 2'b01;
                // After a watchdog abort the request stays low for one cycle
                if (!abort_reg) begin
                    mem_req = 1'b1;
                    waiting = 1'b1;
                    if (i_mem_ready_w) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (i_op_w)
                    6'h23, 6'h2B: state_next = S_MEMADR;
                    6'h04:        state_next = S_BRANCH;
                    6'h08:        state_next = S_ADDIEX;
                    6'h02:        state_next = S_JUMP;
                    6'h00: begin
                        if (i_funct_w inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
                            state_next = S_EXECUTE;
                        end else begin
                            illegal    = 1'b1;
                            state_next = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
                        end
                    end
                    default: begin
                        illegal    = 1'b1;
                        state_next = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (i_op_w == 6'h23) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                waiting = 1'b1;
                if (i_mem_ready_w) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                waiting   = 1'b1;
                if (i_mem_ready_w) state_next = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                state_next = S_ALUWB;
                case (i_funct_w)
                    6'h22:   alu_control = 3'b110;
                    6'h24:   alu_control = 3'b000;
                    6'h25:   alu_control = 3'b001;
                    6'h2A:   alu_control = 3'b111;
                    default: alu_control = 3'b010;
                endcase
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                pc_write    = i_zero_w;
                state_next  = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                alu_control = 3'b000;
                halted      = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        // Ready in the expiry cycle wins, so expiry requires ready low
        expired = (TIMEOUT > 0) && waiting && !i_mem_ready_w &&
                  (count_reg == CW'(TIMEOUT - 1));
        if (expired) begin
            timeout    = 1'b1;
            state_next = S_FETCH;
            abort_next = 1'b1;
        end
        count_next = ((TIMEOUT > 0) && waiting && !i_mem_ready_w && !expired) ?
                     count_reg + CW'(1) : '0;
    end

    // Reset gates every output combinationally so an access aborts without a clock edge
    assign o_mem_req_w     = mem_req    & ~i_rst_w;
    assign o_iord_w        = iord       & ~i_rst_w;
    assign o_mem_write_w   = mem_write  & ~i_rst_w;
    assign o_ir_write_w    = ir_write   & ~i_rst_w;
    assign o_pc_write_w    = pc_write   & ~i_rst_w;
    assign o_reg_dst_w     = reg_dst    & ~i_rst_w;
    assign o_mem_to_reg_w  = mem_to_reg & ~i_rst_w;
    assign o_reg_write_w   = reg_write  & ~i_rst_w;
    assign o_alu_src_a_w   = alu_src_a  & ~i_rst_w;
    assign o_alu_src_b_w   = i_rst_w ? 2'b00 : alu_src_b;
    assign o_alu_control_w = i_rst_w ? 3'b000 : alu_control;
    assign o_pc_src_w      = i_rst_w ? 2'b00 : pc_src;
    assign o_illegal_w     = illegal    & ~i_rst_w;
    assign o_timeout_w     = timeout    & ~i_rst_w;
    assign o_halted_w      = halted     & ~i_rst_w;
    assign o_state_w       = i_rst_w ? 4'd0 : state_reg;
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: two instances (resume / halt on illegal),
// expected output vectors queued at drive time and compared at the falling edge.
module tb_mc_controller;
    typedef struct packed {
        logic [3:0] state;
        logic       mem_req, iord, mem_write, ir_write, pc_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       illegal, timeout, halted;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst, ready, zero;
    logic [5:0] op, funct;

    logic [3:0] state [2];
    logic       mem_req [2], iord [2], mem_write [2], ir_write [2], pc_write [2];
    logic       reg_dst [2], mem_to_reg [2], reg_write [2], alu_src_a [2];
    logic [1:0] alu_src_b [2], pc_src [2];
    logic [2:0] alu_control [2];
    logic       illegal [2], timeout [2], halted [2];
    outs_t      ov [2];

    int vectors = 0;
    int miscompares = 0;
    outs_t exp_q [$];
    string tag_q [$];
    outs_t mon_e;
    string mon_t;

    logic [5:0] r_funct [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] r_alu   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mc_controller #(.TIMEOUT(4), .ILLEGAL_HALT(gi)) dut (
            .i_clk_w(clk), .i_rst_w(rst), .i_op_w(op), .i_funct_w(funct),
            .i_zero_w(zero), .i_mem_ready_w(ready),
            .o_mem_req_w(mem_req[gi]), .o_iord_w(iord[gi]),
            .o_mem_write_w(mem_write[gi]), .o_ir_write_w(ir_write[gi]),
            .o_pc_write_w(pc_write[gi]), .o_reg_dst_w(reg_dst[gi]),
            .o_mem_to_reg_w(mem_to_reg[gi]), .o_reg_write_w(reg_write[gi]),
            .o_alu_src_a_w(alu_src_a[gi]), .o_alu_src_b_w(alu_src_b[gi]),
            .o_alu_control_w(alu_control[gi]), .o_pc_src_w(pc_src[gi]),
            .o_illegal_w(illegal[gi]), .o_timeout_w(timeout[gi]),
            .o_halted_w(halted[gi]), .o_state_w(state[gi])
        );
        assign ov[gi] = {state[gi], mem_req[gi], iord[gi], mem_write[gi], ir_write[gi],
                         pc_write[gi], reg_dst[gi], mem_to_reg[gi], reg_write[gi],
                         alu_src_a[gi], alu_src_b[gi], alu_control[gi], pc_src[gi],
                         illegal[gi], timeout[gi], halted[gi]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Reference output table: static outputs of each state
    function automatic outs_t base(input logic [3:0] st);
        outs_t e = '0;
        e.state = st;
        e.alu_control = 3'b010;
        case (st)
            4'd0:  begin e.mem_req = 1; e.alu_src_b = 2'b01; end
            4'd1:  e.alu_src_b = 2'b11;
            4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4'd3:  begin e.mem_req = 1; e.iord = 1; end
            4'd4:  begin e.mem_to_reg = 1; e.reg_write = 1; end
            4'd5:  begin e.mem_req = 1; e.iord = 1; e.mem_write = 1; end
            4'd6:  e.alu_src_a = 1;
            4'd7:  begin e.reg_dst = 1; e.reg_write = 1; end
            4'd8:  begin e.alu_src_a = 1; e.alu_control = 3'b110; e.pc_src = 2'b01; end
            4'd9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4'd10: e.reg_write = 1;
            4'd11: begin e.pc_src = 2'b10; e.pc_write = 1; end
            4'd12: begin e.alu_control = 3'b000; e.halted = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic outs_t fdone();
        outs_t e = base(4'd0);
        e.ir_write = 1;
        e.pc_write = 1;
        return e;
    endfunction

    function automatic outs_t aborted();
        outs_t e = base(4'd0);
        e.mem_req = 0;
        return e;
    endfunction

    function automatic outs_t with_tmo(input logic [3:0] st);
        outs_t e = base(st);
        e.timeout = 1;
        return e;
    endfunction

    function automatic outs_t with_ill();
        outs_t e = base(4'd1);
        e.illegal = 1;
        return e;
    endfunction

    task automatic apply(input string tag, input logic rdy, input logic zr, input outs_t e);
        ready = rdy;
        zero  = zr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            check(mon_t, {9'd0, ov[0]}, {9'd0, mon_e});
        end
    end

    initial begin
        outs_t e;
        rst = 1; ready = 0; zero = 0; op = 6'h00; funct = 6'h00;
        #2;
        check("rst_out0", {9'd0, ov[0]}, 32'd0);
        check("rst_out1", {9'd0, ov[1]}, 32'd0);
        @(posedge clk); #1 rst = 0;

        op = 6'h23;
        apply("lw_fetch", 1, 0, fdone());
        apply("lw_dec", 1, 0, base(4'd1));
        apply("lw_adr", 1, 0, base(4'd2));
        apply("lw_read", 1, 0, base(4'd3));
        apply("lw_wb", 1, 0, base(4'd4));

        apply("lww_fetch", 1, 0, fdone());
        apply("lww_dec", 1, 0, base(4'd1));
        apply("lww_adr", 1, 0, base(4'd2));
        apply("lww_wait1", 0, 0, base(4'd3));
        apply("lww_wait2", 0, 0, base(4'd3));
        apply("lww_read", 1, 0, base(4'd3));
        apply("lww_wb", 1, 0, base(4'd4));

        op = 6'h2B;
        apply("sw_fetch", 1, 0, fdone());
        apply("sw_dec", 1, 0, base(4'd1));
        apply("sw_adr", 1, 0, base(4'd2));
        apply("sw_write", 1, 0, base(4'd5));

        op = 6'h00;
        for (int i = 0; i < 5; i++) begin
            funct = r_funct[i];
            apply("r_fetch", 1, 0, fdone());
            apply("r_dec", 1, 0, base(4'd1));
            e = base(4'd6);
            e.alu_control = r_alu[i];
            apply("r_exec", 1, 0, e);
            apply("r_wb", 1, 0, base(4'd7));
        end

        op = 6'h08;
        apply("addi_fetch", 1, 0, fdone());
        apply("addi_dec", 1, 0, base(4'd1));
        apply("addi_ex", 1, 0, base(4'd9));
        apply("addi_wb", 1, 0, base(4'd10));

        op = 6'h04;
        for (int z = 1; z >= 0; z--) begin
            apply("beq_fetch", 1, 1'(z), fdone());
            apply("beq_dec", 1, 1'(z), base(4'd1));
            e = base(4'd8);
            e.pc_write = 1'(z);
            apply("beq_branch", 1, 1'(z), e);
        end

        op = 6'h02;
        apply("j_fetch", 1, 0, fdone());
        apply("j_dec", 1, 0, base(4'd1));
        apply("j_jump", 1, 0, base(4'd11));

        // Two back-to-back fetch timeouts: the second proves the count restarted at 0
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) apply("fetch_wait", 0, 0, base(4'd0));
            apply("fetch_tmo", 0, 0, with_tmo(4'd0));
            apply("fetch_abort", 0, 0, aborted());
        end
        for (int i = 0; i < 3; i++) apply("late_wait", 0, 0, base(4'd0));
        apply("late_ready", 1, 0, fdone());
        apply("late_dec", 1, 0, base(4'd1));
        apply("late_jump", 1, 0, base(4'd11));

        op = 6'h2B;
        apply("swt_fetch", 1, 0, fdone());
        apply("swt_dec", 1, 0, base(4'd1));
        apply("swt_adr", 1, 0, base(4'd2));
        for (int i = 0; i < 3; i++) apply("swt_wait", 0, 0, base(4'd5));
        apply("swt_tmo", 0, 0, with_tmo(4'd5));
        apply("swt_abort", 0, 0, aborted());
        apply("swt_refetch", 1, 0, fdone());
        apply("swt_dec2", 1, 0, base(4'd1));
        apply("swt_adr2", 1, 0, base(4'd2));
        apply("swt_write", 1, 0, base(4'd5));

        op = 6'h3F;
        apply("ill_fetch", 1, 0, fdone());
        apply("ill_dec", 1, 0, with_ill());
        apply("ill_refetch", 1, 0, fdone());
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_hold", {9'd0, ov[1]}, {9'd0, base(4'd12)});
            @(posedge clk); #1;
        end

        rst = 1;
        #1;
        check("halt_rst0", {9'd0, ov[0]}, 32'd0);
        check("halt_rst1", {9'd0, ov[1]}, 32'd0);
        @(posedge clk); #1 rst = 0;
        ready = 1; op = 6'h00; funct = 6'h21;
        @(negedge clk);
        check("rst_exit0", {9'd0, ov[0]}, {9'd0, fdone()});
        check("rst_exit1", {9'd0, ov[1]}, {9'd0, fdone()});
        @(posedge clk); #1;
        apply("funct_ill", 1, 0, with_ill());
        apply("funct_ill_refetch", 1, 0, fdone());

        // Asynchronous reset in the middle of a store with the counter at 2
        op = 6'h2B;
        apply("ar_dec", 1, 0, base(4'd1));
        apply("ar_adr", 1, 0, base(4'd2));
        apply("ar_wait1", 0, 0, base(4'd5));
        apply("ar_wait2", 0, 0, base(4'd5));
        #1;
        check("ar_pre", {9'd0, ov[0]}, {9'd0, base(4'd5)});
        rst = 1;
        #1;
        check("ar_drop", {9'd0, ov[0]}, 32'd0);
        @(posedge clk); #1;
        check("ar_hold", {9'd0, ov[0]}, 32'd0);
        rst = 0;
        for (int i = 0; i < 3; i++) apply("ar_fetch_wait", 0, 0, base(4'd0));
        apply("ar_fetch_tmo", 0, 0, with_tmo(4'd0));
        apply("ar_fetch_abort", 0, 0, aborted());

        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
